// File: rtl/cnn_ctrl_pkg.sv
// Shared control definitions for the CNN layer sequencer: FSM state codes
// and small sizing helpers.
package cnn_ctrl_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_LAUNCH  = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT    = 3'd2;
  localparam logic [ST_W-1:0] ST_ADVANCE = 3'd3;
  localparam logic [ST_W-1:0] ST_FINISH  = 3'd4;
  localparam logic [ST_W-1:0] ST_ABORT   = 3'd5;

  // conv, relu, pool, fc
  function automatic int default_num_stages();
    return 4;
  endfunction

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cnn_stage_watchdog.sv
// Per-stage hang detector: counts cycles since the launch pulse and flags the
// terminal count TIMEOUT_CYCLES-1.
module cnn_stage_watchdog
  import cnn_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = clog2_min1(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter parks on the terminal value so the flag stays up until cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TC_VAL)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Layer-stage sequencer: launches each CNN stage in turn, tracks the ping-pong
// buffer, latches the prediction. Optional cycle counter under CNN_SEQ_PERF_EN.
module cnn_layer_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int NUM_STAGES     = default_num_stages(),
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int IDX_W          = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_STAGES-1:0] stage_done,
  input  logic                  prediction_in,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic [IDX_W-1:0]      stage_idx,
  output logic                  buf_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  prediction,
  output logic                  error
`ifdef CNN_SEQ_PERF_EN
  ,
  output logic [31:0]           total_cycles
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  logic [ST_W-1:0]  state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             buf_q, buf_d;
  logic             pred_q, pred_d;
  logic             err_q, err_d;

  logic done_hit;
  logic last_stage;
  logic wd_clr;
  logic wd_en;
  logic wd_tc;

  always_comb begin
    done_hit = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        done_hit = stage_done[k];
      end
    end
  end

  assign last_stage = (idx_q == LAST_IDX);

  // Intermediate hand-offs go straight from WAIT to the next LAUNCH, toggling
  // the bank on the way, so each stage costs its own latency plus one cycle.
  // Only the final stage passes through ADVANCE before FINISH.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    pred_d  = pred_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          buf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_hit) begin
          if (last_stage) begin
            pred_d  = prediction_in;
            state_d = ST_ADVANCE;
          end else begin
            idx_d   = idx_q + 1'b1;
            buf_d   = ~buf_q;
            state_d = ST_LAUNCH;
          end
        end else if (wd_tc) begin
          state_d = ST_ABORT;
        end
      end
      ST_ADVANCE: begin
        buf_d   = ~buf_q;
        state_d = ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      ST_ABORT: begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      buf_q   <= 1'b0;
      pred_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      pred_q  <= pred_d;
      err_q   <= err_d;
    end
  end

  // Watchdog reads zero during LAUNCH, so it equals cycles since the pulse.
  assign wd_clr = (state_d == ST_LAUNCH);
  assign wd_en  = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);

  cnn_stage_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (wd_clr),
    .en_i   (wd_en),
    .tc_o   (wd_tc)
  );

  always_comb begin
    stage_start = '0;
    if (state_q == ST_LAUNCH) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (idx_q == IDX_W'(k)) begin
          stage_start[k] = 1'b1;
        end
      end
    end
  end

  assign busy       = (state_q == ST_LAUNCH) || (state_q == ST_WAIT) ||
                      (state_q == ST_ADVANCE);
  assign done       = (state_q == ST_FINISH);
  assign stage_idx  = idx_q;
  assign buf_sel    = buf_q;
  assign prediction = pred_q;
  assign error      = err_q;

`ifdef CNN_SEQ_PERF_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if ((state_q == ST_IDLE) && start) begin
      cyc_d = '0;
    end else if (busy && (cyc_q != 32'hFFFF_FFFF)) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign total_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: directed and randomized runs checked against
// a schedule model built from per-stage latencies.
module tb_cnn_layer_sequencer;

  localparam int NS = 4;
  localparam int TO = 16;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [NS-1:0] stage_done = '0;
  logic          prediction_in = 1'b0;
  logic [NS-1:0] stage_start;
  logic [IW-1:0] stage_idx;
  logic          buf_sel, busy, done, prediction, error;
`ifdef CNN_SEQ_PERF_EN
  logic [31:0]   total_cycles;
`endif

  cnn_layer_sequencer #(
    .NUM_STAGES     (NS),
    .TIMEOUT_CYCLES (TO),
    .IDX_W          (IW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stage_done    (stage_done),
    .prediction_in (prediction_in),
    .stage_start   (stage_start),
    .stage_idx     (stage_idx),
    .buf_sel       (buf_sel),
    .busy          (busy),
    .done          (done),
    .prediction    (prediction),
    .error         (error)
`ifdef CNN_SEQ_PERF_EN
    ,
    .total_cycles  (total_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  int dly[NS];
  int hang;
  int early;
  int noise;
  int pred_val;
  int rst_stage;

  task automatic chk(input string tag, input int c, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, c, got, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start"}, -1, 32'(stage_start), 0);
    chk({tag, "_idx"},   -1, 32'(stage_idx), 0);
    chk({tag, "_buf"},   -1, 32'(buf_sel), 0);
    chk({tag, "_busy"},  -1, 32'(busy), 0);
    chk({tag, "_done"},  -1, 32'(done), 0);
    chk({tag, "_pred"},  -1, 32'(prediction), 0);
    chk({tag, "_err"},   -1, 32'(error), 0);
`ifdef CNN_SEQ_PERF_EN
    chk({tag, "_perf"},  -1, total_cycles, 0);
`endif
  endtask

  // One run: cycle 0 carries the start pulse. Stage k launches at L[k] and
  // answers at L[k]+dly[k]; the next stage launches one cycle later. After the
  // last answer there is one ADVANCE cycle, then the done pulse.
  task automatic run();
    int L[NS];
    int t, abt, fin, endc, last_c, nl, rst_at, due, ei, w;
    logic [NS-1:0] sd, es;
    logic          pin;
    t = 1; abt = -1; fin = -1; nl = 0; rst_at = -1;
    for (int k = 0; k < NS; k++) begin
      L[k] = t;
      nl = k + 1;
      if (k == hang) begin
        abt = t + TO;
        break;
      end
      t = t + dly[k] + 1;
    end
    if (abt < 0) fin = L[NS-1] + dly[NS-1] + 2;
    endc = (abt >= 0) ? abt : fin;
    last_c = endc + 3;
    if (rst_stage >= 0 && rst_stage < nl) rst_at = L[rst_stage] + 2;

    for (int c = 0; c <= last_c; c++) begin
      @(posedge clk);
      #1;
      start = (c == 0) || (noise != 0 && c <= endc && $urandom_range(0, 3) == 0);
      pin = 1'($urandom_range(0, 1));
      sd = '0;
      for (int j = 0; j < NS; j++) begin
        due = (j == hang) ? L[j] + TO : L[j] + dly[j];
        if (noise != 0 && !(j < nl && c > L[j] && c < due))
          sd[j] = ($urandom_range(0, 7) == 0);
        if (j < nl && j != hang && c == L[j] + dly[j]) begin
          sd[j] = 1'b1;
          if (j == NS - 1) pin = pred_val[0];
        end
        if (j < nl && j == hang && early != 0 && c == L[j]) sd[j] = 1'b1;
      end
      stage_done = sd;
      prediction_in = pin;
      @(negedge clk);

      es = '0;
      for (int k = 0; k < nl; k++) if (c == L[k]) es[k] = 1'b1;
      chk("stage_start", c, 32'(stage_start), 32'(es));
      chk("busy", c, 32'(busy), 32'(c >= 1 && c < endc));
      chk("done", c, 32'(done), 32'(c == fin));
      if (c >= 1) begin
        ei = 0;
        for (int k = 0; k < nl; k++) if (L[k] <= c) ei = k;
        chk("stage_idx", c, 32'(stage_idx), 32'(ei));
        chk("error", c, 32'(error), 32'(abt >= 0 && c > abt));
`ifdef CNN_SEQ_PERF_EN
        chk("total_cycles", c, total_cycles, 32'(((c - 1) < (endc - 1)) ? (c - 1) : (endc - 1)));
`endif
      end
      for (int k = 0; k < nl; k++) begin
        w = (k == hang) ? TO - 1 : dly[k];
        if (c >= L[k] && c <= L[k] + w) chk("buf_sel", c, 32'(buf_sel), 32'(k % 2));
      end
      if (fin >= 0 && c >= fin) begin
        chk("buf_final", c, 32'(buf_sel), 32'(NS % 2));
        chk("prediction", c, 32'(prediction), 32'(pred_val));
      end

      if (c == rst_at) begin
        #2 reset = 1'b0;
        start = 1'b0;
        stage_done = '0;
        #1 chk_reset_vals("async_rst");
        for (int r = 0; r < 2; r++) begin
          @(negedge clk);
          chk("rst_hold_done", c, 32'(done), 0);
          chk("rst_hold_busy", c, 32'(busy), 0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        break;
      end
    end
    start = 1'b0;
    stage_done = '0;
  endtask

  task automatic set_dly(input int v);
    for (int k = 0; k < NS; k++) dly[k] = v;
  endtask

  task automatic set_dly_rand();
    for (int k = 0; k < NS; k++) dly[k] = $urandom_range(1, TO - 1);
  endtask

  task automatic defaults();
    hang = -1; early = 0; noise = 0; pred_val = 1; rst_stage = -1;
  endtask

  initial begin
    defaults();
    set_dly(3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    // Normal run: 3-cycle engines, prediction 1, done at start+18.
    defaults(); set_dly(3); pred_val = 1;
    run();

    // Minimum latency: done at start+10, busy 9 cycles.
    defaults(); set_dly(1); pred_val = 0;
    run();

    // Spurious stage_done bits and start pulses while busy.
    defaults(); set_dly_rand(); noise = 1; pred_val = 1;
    run();

    // stage_done[0] only alongside its launch pulse: run times out.
    defaults(); set_dly(2); hang = 0; early = 1;
    run();

    // Stage 1 never answers.
    defaults(); set_dly_rand(); hang = 1;
    run();

    // Fresh start clears the sticky error and completes.
    defaults(); set_dly(2); pred_val = 1;
    run();

    // Answers land on the watchdog terminal cycle: completion wins.
    defaults(); set_dly(TO - 1); pred_val = 0;
    run();

    // Asynchronous reset during WAIT of stage 2, then a clean run.
    defaults(); set_dly(4); rst_stage = 2;
    run();
    defaults(); set_dly(1); pred_val = 1;
    run();

    for (int i = 0; i < 20; i++) begin
      defaults();
      set_dly_rand();
      noise = 1;
      pred_val = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) begin
        hang = $urandom_range(0, NS - 1);
        early = $urandom_range(0, 1);
      end
      run();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
